// File: rtl/cmplx_mult_host.sv
// cmplx_mult_host
// Host-side sequencer for an external complex multiplier. Operand sets are
// queued in a small FIFO, issued one at a time to the multiplier, and the
// result is captured and held for a downstream consumer. Only one multiplier
// transaction is ever outstanding; a result that never arrives is abandoned
// after TIMEOUT cycles and flagged in a sticky error bit.
//
// Ports
//   clk, rstn        clock, asynchronous active-low reset
//   sw_rst           synchronous software reset (same effect as rstn)
//   in_val/in_ready  upstream operand handshake, in_a_*/in_b_* operands
//   op_val/op_ready  operand handshake toward the multiplier, op_1_*/op_2_*
//   res_val/res_ready multiplier result handshake, res_re/res_im
//   out_val/out_ready downstream result handshake, out_re/out_im
//   fifo_level       operand FIFO occupancy
//   done_cnt         completed transactions (wraps)
//   timeout_err      sticky result-timeout flag
//
// state    | meaning
// IDLE     | waiting for a queued operand set
// SEND     | op_val high, operands held until the multiplier takes them
// WAIT_RES | res_ready high, counting cycles toward TIMEOUT
// DELIVER  | out_val high, captured result held until downstream takes it

module cmplx_mult_host #(
    parameter int DW      = 8,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 32
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      sw_rst,
    input  logic                      in_val,
    output logic                      in_ready,
    input  logic [DW-1:0]             in_a_re,
    input  logic [DW-1:0]             in_a_im,
    input  logic [DW-1:0]             in_b_re,
    input  logic [DW-1:0]             in_b_im,
    output logic                      op_val,
    input  logic                      op_ready,
    output logic [DW-1:0]             op_1_re,
    output logic [DW-1:0]             op_1_im,
    output logic [DW-1:0]             op_2_re,
    output logic [DW-1:0]             op_2_im,
    input  logic                      res_val,
    output logic                      res_ready,
    input  logic [2*DW:0]             res_re,
    input  logic [2*DW:0]             res_im,
    output logic                      out_val,
    input  logic                      out_ready,
    output logic [2*DW:0]             out_re,
    output logic [2*DW:0]             out_im,
    output logic [$clog2(DEPTH):0]    fifo_level,
    output logic [15:0]               done_cnt,
    output logic                      timeout_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [AW:0]   FULL_LVL = (AW + 1)'(DEPTH);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND     = 2'd1,
        WAIT_RES = 2'd2,
        DELIVER  = 2'd3
    } state_t;

    state_t           state;
    logic [4*DW-1:0]  mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             avail_q;
    logic [CW-1:0]    tmo_cnt;
    logic             push;
    logic             pop;
    logic [4*DW-1:0]  head;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign fifo_level = wr_ptr - rd_ptr;
    assign in_ready   = (fifo_level != FULL_LVL);
    assign push       = in_val && in_ready;
    assign pop        = op_val && op_ready;
    assign head       = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {in_a_re, in_a_im, in_b_re, in_b_im};
        end
    end

    // avail_q is a registered "FIFO not empty". It adds one cycle between a
    // push and the IDLE->SEND decision. It cannot be stale on entry to IDLE:
    // the only pop happens leaving SEND, and WAIT_RES plus DELIVER take at
    // least two cycles, so avail_q is refreshed before IDLE is reached again.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            avail_q     <= 1'b0;
            tmo_cnt     <= '0;
            op_val      <= 1'b0;
            res_ready   <= 1'b0;
            out_val     <= 1'b0;
            op_1_re     <= '0;
            op_1_im     <= '0;
            op_2_re     <= '0;
            op_2_im     <= '0;
            out_re      <= '0;
            out_im      <= '0;
            done_cnt    <= '0;
            timeout_err <= 1'b0;
        end else if (sw_rst) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            avail_q     <= 1'b0;
            tmo_cnt     <= '0;
            op_val      <= 1'b0;
            res_ready   <= 1'b0;
            out_val     <= 1'b0;
            op_1_re     <= '0;
            op_1_im     <= '0;
            op_2_re     <= '0;
            op_2_im     <= '0;
            out_re      <= '0;
            out_im      <= '0;
            done_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (AW + 1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW + 1)'(1);
            end
            avail_q <= (fifo_level != '0);

            case (state)
                IDLE: begin
                    if (avail_q) begin
                        {op_1_re, op_1_im, op_2_re, op_2_im} <= head;
                        op_val <= 1'b1;
                        state  <= SEND;
                    end
                end
                SEND: begin
                    if (op_ready) begin
                        op_val    <= 1'b0;
                        res_ready <= 1'b1;
                        tmo_cnt   <= '0;
                        state     <= WAIT_RES;
                    end
                end
                WAIT_RES: begin
                    // A result arriving on the last allowed cycle still wins.
                    if (res_val) begin
                        out_re    <= res_re;
                        out_im    <= res_im;
                        res_ready <= 1'b0;
                        out_val   <= 1'b1;
                        state     <= DELIVER;
                    end else if (tmo_cnt == TMO_LAST) begin
                        timeout_err <= 1'b1;
                        res_ready   <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + CW'(1);
                    end
                end
                DELIVER: begin
                    if (out_ready) begin
                        out_val  <= 1'b0;
                        done_cnt <= done_cnt + 16'd1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
